// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and the data RAM port.
// Committed stores enter a circular FIFO and drain in order over a req/ack handshake.
// Loads get zero-latency store-to-load forwarding or a conflict flag for the hazard unit.
// Optional feature: define STORE_BUFFER_COALESCE_EN to merge a store into the youngest entry
// when both target the same doubleword.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // Store enqueue from EX/MEM
    input  logic                      st_valid_i,
    output logic                      st_ready_o,
    input  logic [ADDR_W-1:0]         st_addr_i,
    input  logic [DATA_W-1:0]         st_data_i,
    input  logic [DATA_W/8-1:0]       st_mask_i,
    // Load lookup
    input  logic                      ld_req_i,
    input  logic [ADDR_W-1:0]         ld_addr_i,
    input  logic [DATA_W/8-1:0]       ld_mask_i,
    output logic                      ld_hit_o,
    output logic [DATA_W-1:0]         ld_data_o,
    output logic                      ld_conflict_o,
    // RAM drain port
    output logic                      ram_req_o,
    output logic                      ram_we_o,
    output logic [ADDR_W-1:0]         ram_addr_o,
    output logic [DATA_W-1:0]         ram_data_o,
    output logic [DATA_W/8-1:0]       ram_mask_o,
    input  logic                      ram_ack_i,
    // Status
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TAG_W  = ADDR_W - 3;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry storage: doubleword tag, lane-aligned data, byte enables
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [MASK_W-1:0] mask_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full;
    logic             not_empty;
    logic             merge_ok;
    logic             enq_alloc;
    logic             enq_merge;
    logic             pop;
    logic [TAG_W-1:0] st_tag;
    logic [TAG_W-1:0] ld_tag;

    // Byte offsets are irrelevant: everything works on doubleword granularity
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{st_addr_i[2:0], ld_addr_i[2:0]};

    assign st_tag = st_addr_i[ADDR_W-1:3];
    assign ld_tag = ld_addr_i[ADDR_W-1:3];

    assign full      = (count_q == FULL_CNT);
    assign not_empty = (count_q != '0);

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PTR_W-1:0]  young_idx;
    logic [DATA_W-1:0] st_bytes;

    assign young_idx = tail_q - PTR_W'(1);

    // Expand the store byte mask into a bit mask for the merge
    always_comb begin
        st_bytes = '0;
        for (int b = 0; b < int'(MASK_W); b++) begin
            st_bytes[b*8 +: 8] = {8{st_mask_i[b]}};
        end
    end

    // Needing two entries keeps the head, which the RAM may be sampling, untouched
    assign merge_ok = (count_q >= CNT_W'(2)) && (tag_q[young_idx] == st_tag);
`else
    assign merge_ok = 1'b0;
`endif

    // A merge needs no free slot, so it is accepted even when full
    assign st_ready_o = !full || merge_ok;
    assign enq_merge  = st_valid_i && merge_ok;
    assign enq_alloc  = st_valid_i && !merge_ok && !full;
    assign pop        = not_empty && ram_ack_i;

    // Next-state pointers and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_alloc) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({enq_alloc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry writes: allocate at tail, or merge into the youngest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else if (enq_alloc) begin
            tag_q[tail_q]  <= st_tag;
            data_q[tail_q] <= st_data_i;
            mask_q[tail_q] <= st_mask_i;
`ifdef STORE_BUFFER_COALESCE_EN
        end else if (enq_merge) begin
            data_q[young_idx] <= (data_q[young_idx] & ~st_bytes) | (st_data_i & st_bytes);
            mask_q[young_idx] <= mask_q[young_idx] | st_mask_i;
`endif
        end
    end

    // Drain port presents the head entry; zeroed while idle so stale slots never leak out
    always_comb begin
        ram_req_o  = not_empty;
        ram_we_o   = not_empty;
        ram_addr_o = '0;
        ram_data_o = '0;
        ram_mask_o = '0;
        if (not_empty) begin
            ram_addr_o = {tag_q[head_q], 3'b000};
            ram_data_o = data_q[head_q];
            ram_mask_o = mask_q[head_q];
        end
    end

    // Forwarding lookup: youngest to oldest, first overlapping same-doubleword entry decides
    always_comb begin
        logic             decided;
        logic [PTR_W-1:0] idx;
        logic [MASK_W-1:0] overlap;
        ld_hit_o      = 1'b0;
        ld_conflict_o = 1'b0;
        ld_data_o     = '0;
        decided       = 1'b0;
        idx           = '0;
        overlap       = '0;
        if (ld_req_i) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                idx     = tail_q - PTR_W'(k + 1);
                overlap = mask_q[idx] & ld_mask_i;
                if (!decided && (k < int'(count_q)) && (tag_q[idx] == ld_tag) &&
                    (overlap != '0)) begin
                    decided = 1'b1;
                    if (overlap == ld_mask_i) begin
                        ld_hit_o  = 1'b1;
                        ld_data_o = data_q[idx];
                    end else begin
                        ld_conflict_o = 1'b1;
                    end
                end
            end
        end
    end

    assign empty_o = !not_empty;
    assign count_o = count_q;

`ifndef SYNTHESIS
    // Occupancy bound and head stability while the RAM has not yet accepted it
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count_q <= FULL_CNT)
                else $error("store_buffer: count exceeds depth");
        end
    end

    head_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        (ram_req_o && !ram_ack_i) |=>
            ($stable(ram_addr_o) && $stable(ram_data_o) && $stable(ram_mask_o)));
`endif

endmodule
